// File: rtl/mul_div_unit_pkg.sv
// Shared opcodes, FSM state encoding and sizing helper for the multiply/divide unit.
package mul_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } md_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational multiply/divide datapath producing the HI/LO result for one operation.
module md_compute
  import mul_div_unit_pkg::*;
(
  input  logic [2:0]  mdop,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);

  logic signed [63:0] smul;
  logic        [63:0] umul;
  logic signed [32:0] sdvd;
  logic signed [32:0] sdvs;
  logic signed [32:0] squot;
  logic signed [32:0] srem;
  logic        [31:0] udvs;
  logic        [31:0] uquot;
  logic        [31:0] urem;
  logic               op2_zero;

  assign op2_zero = (op2 == 32'd0);
  assign smul     = $signed({{32{op1[31]}}, op1}) * $signed({{32{op2[31]}}, op2});
  assign umul     = {32'd0, op1} * {32'd0, op2};
  // 33-bit signed divide so that 0x80000000 / -1 yields +2^31 whose low word is 0x80000000.
  assign sdvd     = $signed({op1[31], op1});
  assign sdvs     = op2_zero ? 33'sd1 : $signed({op2[31], op2});
  assign squot    = sdvd / sdvs;
  assign srem     = sdvd % sdvs;
  assign udvs     = op2_zero ? 32'd1 : op2;
  assign uquot    = op1 / udvs;
  assign urem     = op1 % udvs;

  always_comb begin
    res_hi      = 32'd0;
    res_lo      = 32'd0;
    div_by_zero = 1'b0;
    case (md_op_e'(mdop))
      MD_MULT:  {res_hi, res_lo} = smul;
      MD_MULTU: {res_hi, res_lo} = umul;
      MD_DIV: begin
        res_hi      = srem[31:0];
        res_lo      = squot[31:0];
        div_by_zero = op2_zero;
      end
      MD_DIVU: begin
        res_hi      = urem;
        res_lo      = uquot;
        div_by_zero = op2_zero;
      end
      default: begin
        res_hi      = 32'd0;
        res_lo      = 32'd0;
        div_by_zero = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS multiply/divide unit with HI/LO registers and a busy flag for hazard stalls.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  md_state_e   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic        busy_n;
  logic [31:0] hi_n, lo_n;
  logic [31:0] pend_hi, pend_hi_n, pend_lo, pend_lo_n;
  logic        pend_dbz, pend_dbz_n;
  logic [31:0] res_hi, res_lo;
  logic        div_by_zero;

  md_compute u_compute (
    .mdop        (mdop),
    .op1         (op1),
    .op2         (op2),
    .res_hi      (res_hi),
    .res_lo      (res_lo),
    .div_by_zero (div_by_zero)
  );

  // Result is captured at accept; the counter only delays its write-back into HI/LO.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    busy_n     = busy;
    hi_n       = hi;
    lo_n       = lo;
    pend_hi_n  = pend_hi;
    pend_lo_n  = pend_lo;
    pend_dbz_n = pend_dbz;
    case (state)
      S_IDLE: begin
        if (start) begin
          case (md_op_e'(mdop))
            MD_MULT, MD_MULTU: begin
              state_n    = S_MUL;
              cnt_n      = MUL_LOAD;
              busy_n     = 1'b1;
              pend_hi_n  = res_hi;
              pend_lo_n  = res_lo;
              pend_dbz_n = 1'b0;
            end
            MD_DIV, MD_DIVU: begin
              state_n    = S_DIV;
              cnt_n      = DIV_LOAD;
              busy_n     = 1'b1;
              pend_hi_n  = res_hi;
              pend_lo_n  = res_lo;
              pend_dbz_n = div_by_zero;
            end
            MD_MTHI: hi_n = op1;
            MD_MTLO: lo_n = op1;
            default: state_n = S_IDLE;
          endcase
        end else begin
          state_n = S_IDLE;
        end
      end
      S_MUL, S_DIV: begin
        if (cnt == '0) begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
          if (!pend_dbz) begin
            hi_n = pend_hi;
            lo_n = pend_lo;
          end else begin
            hi_n = hi;
            lo_n = lo;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State, counter, pending result and architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      pend_hi  <= 32'd0;
      pend_lo  <= 32'd0;
      pend_dbz <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      busy     <= busy_n;
      hi       <= hi_n;
      lo       <= lo_n;
      pend_hi  <= pend_hi_n;
      pend_lo  <= pend_lo_n;
      pend_dbz <= pend_dbz_n;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, hand corner sequences, random vs. model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  mdop = 3'd0;
  logic [31:0] op1 = 32'd0;
  logic [31:0] op2 = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  logic [31:0] mhi, mlo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_n;
  } vec_t;

  vec_t vecs[11];

  mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdop(mdop),
    .op1(op1), .op2(op2), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural HI/LO.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] h, inout logic [31:0] l, output int n);
    longint sa, sb, sp;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    n = 0;
    case (op)
      3'd1: begin sp = sa * sb; {h, l} = sp; n = 5; end
      3'd2: begin up = {32'd0, a} * {32'd0, b}; {h, l} = up; n = 5; end
      3'd3: begin n = 10; if (b != 32'd0) begin l = 32'(sa / sb); h = 32'(sa % sb); end end
      3'd4: begin n = 10; if (b != 32'd0) begin l = a / b; h = a % b; end end
      3'd5: h = a;
      3'd6: l = a;
      default: n = 0;
    endcase
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int en, input logic [31:0] ph, input logic [31:0] pl);
    int n;
    @(negedge clk);
    start = 1'b1; mdop = op; op1 = a; op2 = b;
    @(posedge clk); #1;
    start = 1'b0; mdop = 3'd0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      chk({name, " hold_hi"}, hi, ph);
      chk({name, " hold_lo"}, lo, pl);
      @(posedge clk); #1;
      n++;
    end
    chk({name, " busy_cycles"}, n, en);
    chk({name, " hi"}, hi, eh);
    chk({name, " lo"}, lo, el);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    chk({name, " idle_timeout"}, busy, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{3'd5, 32'h0000_1234, 32'h0,         32'h0000_1234, 32'h0000_0000, 0};
    vecs[1]  = '{3'd6, 32'h0000_5678, 32'h0,         32'h0000_1234, 32'h0000_5678, 0};
    vecs[2]  = '{3'd1, 32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
    vecs[4]  = '{3'd3, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[5]  = '{3'd4, 32'h0000_0007, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[6]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
    vecs[7]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
    vecs[8]  = '{3'd4, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 10};
    vecs[9]  = '{3'd0, 32'hDEAD_BEEF, 32'h1,         32'h0000_0002, 32'h0000_000E, 0};
    vecs[10] = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset busy", busy, 1'b0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);

    mhi = 32'd0; mlo = 32'd0;
    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_n, mhi, mlo);
      mhi = vecs[i].exp_hi; mlo = vecs[i].exp_lo;
    end

    // DIV with an MTLO pulse in busy cycle 3: MTLO must be dropped.
    @(negedge clk);
    start = 1'b1; mdop = 3'd3; op1 = 32'd100; op2 = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; mdop = 3'd6; op1 = 32'h0000_AAAA;
    @(posedge clk); #1 start = 1'b0;
    chk("mtlo_busy lo_held", lo, mlo);
    wait_idle("mtlo_busy");
    chk("mtlo_busy hi", hi, 32'd1);
    chk("mtlo_busy lo", lo, 32'd33);
    mhi = 32'd1; mlo = 32'd33;

    // MTHI presented exactly at the MULT completion edge: ignored.
    @(negedge clk);
    start = 1'b1; mdop = 3'd1; op1 = 32'd6; op2 = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("cmpl_edge busy_last", busy, 1'b1);
    start = 1'b1; mdop = 3'd5; op1 = 32'h0000_0055;
    @(posedge clk); #1 start = 1'b0;
    chk("cmpl_edge busy", busy, 1'b0);
    chk("cmpl_edge hi", hi, 32'd0);
    chk("cmpl_edge lo", lo, 32'd42);
    @(posedge clk); #1;
    chk("cmpl_edge hi_after", hi, 32'd0);

    // Reset during MULT busy cycle 2: everything cleared, no late write-back.
    @(negedge clk);
    start = 1'b1; mdop = 3'd1; op1 = 32'd3; op2 = 32'd5;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("rst_busy busy", busy, 1'b0);
    chk("rst_busy hi", hi, 32'd0);
    chk("rst_busy lo", lo, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("rst_busy late_lo", lo, 32'd0);
    chk("rst_busy late_busy", busy, 1'b0);

    // Reset and MTHI in the same cycle: reset wins.
    @(negedge clk);
    reset = 1'b1; start = 1'b1; mdop = 3'd5; op1 = 32'h0000_0077;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    chk("rst_start hi", hi, 32'd0);
    mhi = 32'd0; mlo = 32'd0;

    for (int i = 0; i < 30; i++) begin
      logic [2:0] op;
      logic [31:0] a, b, eh, el, ph, pl;
      int n;
      op = 3'($urandom_range(0, 6));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      ph = mhi; pl = mlo; eh = mhi; el = mlo;
      model(op, a, b, eh, el, n);
      run_op($sformatf("rand%0d", i), op, a, b, eh, el, n, ph, pl);
      mhi = eh; mlo = el;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
